// File: rtl/object_position_pkg.sv
// Shared video definitions for the object position blocks and renderers.
//   SCREEN_WIDTH    : visible pixels per line; position arithmetic wraps here
//   RESET_OFFSET    : render pipeline delay added on a visible coarse reset
//   HBLANK_POSITION : position loaded by a coarse reset during blanking
//   move_state_e    : horizontal-motion state (IDLE, MOVING)
//   motion_magnitude: number of steps encoded by a signed 4-bit motion value
package object_position_pkg;

    localparam int unsigned POS_W           = 8;
    localparam int unsigned SCREEN_WIDTH    = 160;
    localparam int unsigned RESET_OFFSET    = 4;
    localparam int unsigned HBLANK_POSITION = 3;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } move_state_e;

    // Absolute value of a signed 4-bit motion value; -8 yields 4'd8 unsigned.
    function automatic logic [3:0] motion_magnitude(input logic [3:0] value);
        logic [3:0] mag;
        if (value[3]) begin
            mag = ~value + 4'd1;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

endpackage

// File: rtl/object_position_wrap.sv
// position_wrap: modulo-SCREEN_WIDTH addition of two in-range values.
// A decrement is expressed as adding SCREEN_WIDTH-1.
//   base_i    : base value, 0..SCREEN_WIDTH-1
//   offset_i  : amount to add, 0..SCREEN_WIDTH-1
//   wrapped_o : (base_i + offset_i) mod SCREEN_WIDTH
module position_wrap
    import object_position_pkg::*;
(
    input  logic [POS_W-1:0] base_i,
    input  logic [POS_W-1:0] offset_i,
    output logic [POS_W-1:0] wrapped_o
);

    logic [POS_W:0] sum_s;

    assign sum_s = {1'b0, base_i} + {1'b0, offset_i};

    // Both operands are below SCREEN_WIDTH, so one conditional subtract suffices.
    always_comb begin
        if (sum_s >= 9'(SCREEN_WIDTH)) begin
            wrapped_o = 8'(sum_s - 9'(SCREEN_WIDTH));
        end else begin
            wrapped_o = sum_s[POS_W-1:0];
        end
    end

endmodule

// File: rtl/object_position.sv
// object_position: horizontal position generator for one movable object.
// Holds the position, compares it with the beam column to emit a one-cycle
// start strobe, and implements coarse reset-to-beam and serial fine motion.
//   clk, reset_n  : clock, asynchronous active-low reset
//   beam_x        : beam column (>= SCREEN_WIDTH means horizontal blank)
//   pixel_enable  : pixel tick qualifying the beam comparison
//   reset_strobe  : coarse reset of position to the beam
//   hmove_value   : signed motion -8..+7, positive moves left
//   hmove_write   : latch hmove_value; hmove_clear zeroes it (clear wins)
//   hmove_strobe  : start applying the motion register
//   step_enable   : one pixel of motion per tick while busy
//   strobe        : registered start-of-object pulse
//   position      : registered position, 0..SCREEN_WIDTH-1
//   busy          : high while motion steps remain
module object_position
    import object_position_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [POS_W-1:0] beam_x,
    input  logic             pixel_enable,
    input  logic             reset_strobe,
    input  logic [3:0]       hmove_value,
    input  logic             hmove_write,
    input  logic             hmove_clear,
    input  logic             hmove_strobe,
    input  logic             step_enable,
    output logic             strobe,
    output logic [POS_W-1:0] position,
    output logic             busy
);

    move_state_e      state_q, state_d;
    logic [POS_W-1:0] position_q, position_d;
    logic             strobe_q, strobe_d;
    logic [3:0]       motion_q, motion_d;
    logic [3:0]       count_q, count_d;
    logic             dir_left_q, dir_left_d;

    logic             beam_visible_s;
    logic             step_now_s;
    logic [POS_W-1:0] coarse_pos_s;
    logic [POS_W-1:0] step_pos_s;
    logic [POS_W-1:0] step_offset_s;

    assign beam_visible_s = (beam_x < 8'(SCREEN_WIDTH));
    // A restart on hmove_strobe takes the cycle; the first move comes later.
    assign step_now_s     = (state_q == MOVING) && step_enable && !hmove_strobe;
    assign step_offset_s  = dir_left_q ? 8'(SCREEN_WIDTH - 1) : 8'd1;

    position_wrap u_coarse_wrap (
        .base_i    (beam_x),
        .offset_i  (8'(RESET_OFFSET)),
        .wrapped_o (coarse_pos_s)
    );

    position_wrap u_step_wrap (
        .base_i    (position_q),
        .offset_i  (step_offset_s),
        .wrapped_o (step_pos_s)
    );

    // Start strobe: match against the current (old) position.
    always_comb begin
        strobe_d = 1'b0;
        if (pixel_enable && beam_visible_s && (beam_x == position_q)) begin
            strobe_d = 1'b1;
        end else begin
            strobe_d = 1'b0;
        end
    end

    // Motion register update; clear has priority over write.
    always_comb begin
        motion_d = motion_q;
        if (hmove_clear) begin
            motion_d = 4'd0;
        end else if (hmove_write) begin
            motion_d = hmove_value;
        end else begin
            motion_d = motion_q;
        end
    end

    // Motion FSM next state: load on hmove_strobe, count down on step ticks.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dir_left_d = dir_left_q;
        if (hmove_strobe) begin
            if (motion_q != 4'd0) begin
                state_d    = MOVING;
                count_d    = motion_magnitude(motion_q);
                dir_left_d = ~motion_q[3];
            end else begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                MOVING: begin
                    if (step_enable) begin
                        count_d = count_q - 4'd1;
                        if (count_q == 4'd1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = MOVING;
                        end
                    end else begin
                        state_d = MOVING;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end
            endcase
        end
    end

    // Position next value: coarse reset overrides a same-cycle motion step.
    always_comb begin
        position_d = position_q;
        if (reset_strobe) begin
            if (beam_visible_s) begin
                position_d = coarse_pos_s;
            end else begin
                position_d = 8'(HBLANK_POSITION);
            end
        end else if (step_now_s) begin
            position_d = step_pos_s;
        end else begin
            position_d = position_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            position_q <= 8'd0;
            strobe_q   <= 1'b0;
            motion_q   <= 4'd0;
            count_q    <= 4'd0;
            dir_left_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            position_q <= position_d;
            strobe_q   <= strobe_d;
            motion_q   <= motion_d;
            count_q    <= count_d;
            dir_left_q <= dir_left_d;
        end
    end

    assign strobe   = strobe_q;
    assign position = position_q;
    assign busy     = (state_q == MOVING);

endmodule

// File: tb/tb_object_position.sv
// Directed self-checking bench for object_position.
module tb_object_position;

    logic       clk;
    logic       reset_n;
    logic [7:0] beam_x;
    logic       pixel_enable;
    logic       reset_strobe;
    logic [3:0] hmove_value;
    logic       hmove_write;
    logic       hmove_clear;
    logic       hmove_strobe;
    logic       step_enable;
    logic       strobe;
    logic [7:0] position;
    logic       busy;

    int n_cmp;
    int n_err;
    int strobe_count;

    object_position dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .beam_x       (beam_x),
        .pixel_enable (pixel_enable),
        .reset_strobe (reset_strobe),
        .hmove_value  (hmove_value),
        .hmove_write  (hmove_write),
        .hmove_clear  (hmove_clear),
        .hmove_strobe (hmove_strobe),
        .step_enable  (step_enable),
        .strobe       (strobe),
        .position     (position),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coarse_reset(input logic [7:0] bx);
        beam_x       = bx;
        reset_strobe = 1'b1;
        tick();
        reset_strobe = 1'b0;
        beam_x       = 8'd200;
    endtask

    task automatic load_and_start(input logic [3:0] v);
        hmove_value = v;
        hmove_write = 1'b1;
        tick();
        hmove_write  = 1'b0;
        hmove_strobe = 1'b1;
        tick();
        hmove_strobe = 1'b0;
    endtask

    task automatic step_check(input string tag, input int exp_pos, input int exp_busy);
        step_enable = 1'b1;
        tick();
        step_enable = 1'b0;
        check({tag, "_pos"}, int'(position), exp_pos);
        check({tag, "_busy"}, int'(busy), exp_busy);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        beam_x = 8'd200;
        pixel_enable = 1'b0;
        reset_strobe = 1'b0;
        hmove_value = 4'd0;
        hmove_write = 1'b0;
        hmove_clear = 1'b0;
        hmove_strobe = 1'b0;
        step_enable = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_pos", int'(position), 0);
        check("rst_strobe", int'(strobe), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        tick();

        // hmove_strobe with empty motion register stays idle
        hmove_strobe = 1'b1;
        tick();
        hmove_strobe = 1'b0;
        check("empty_strobe_busy", int'(busy), 0);

        // Coarse reset in visible region
        coarse_reset(8'd50);
        check("coarse_50", int'(position), 54);

        // Beam sweep: one strobe, one cycle after beam_x==54
        strobe_count = 0;
        pixel_enable = 1'b1;
        for (int i = 0; i < 228; i++) begin
            beam_x = 8'(i);
            tick();
            check("sweep_strobe", int'(strobe), (i == 54) ? 1 : 0);
            if (strobe) strobe_count++;
        end
        pixel_enable = 1'b0;
        beam_x = 8'd200;
        tick();
        check("sweep_count", strobe_count, 1);

        // Coarse reset wrap and blanking
        coarse_reset(8'd158);
        check("coarse_158", int'(position), 2);
        coarse_reset(8'd200);
        check("coarse_200", int'(position), 3);

        // Motion +3 from 54
        coarse_reset(8'd50);
        load_and_start(4'd3);
        check("mv3_start_busy", int'(busy), 1);
        check("mv3_start_pos", int'(position), 54);
        step_check("mv3_s1", 53, 1);
        step_check("mv3_s2", 52, 1);
        step_check("mv3_s3", 51, 0);

        // Motion -8 from 54
        coarse_reset(8'd50);
        load_and_start(4'b1000);
        for (int i = 1; i <= 7; i++) begin
            step_check("mvm8", 54 + i, 1);
        end
        step_check("mvm8_last", 62, 0);

        // Wrap left from 1
        coarse_reset(8'd157);
        check("coarse_157", int'(position), 1);
        load_and_start(4'd3);
        step_check("wrapl_s1", 0, 1);
        step_check("wrapl_s2", 159, 1);
        step_check("wrapl_s3", 158, 0);

        // Wrap right from 159
        coarse_reset(8'd155);
        check("coarse_155", int'(position), 159);
        load_and_start(4'b1110);
        step_check("wrapr_s1", 0, 1);
        step_check("wrapr_s2", 1, 0);

        // Coarse reset coincident with a match
        coarse_reset(8'd50);
        beam_x = 8'd54;
        pixel_enable = 1'b1;
        reset_strobe = 1'b1;
        tick();
        reset_strobe = 1'b0;
        pixel_enable = 1'b0;
        beam_x = 8'd200;
        check("coll_strobe", int'(strobe), 1);
        check("coll_pos", int'(position), 58);
        tick();
        check("coll_strobe_off", int'(strobe), 0);

        // Restart after one of three steps
        load_and_start(4'd3);
        step_check("rs_s1", 57, 1);
        hmove_strobe = 1'b1;
        tick();
        hmove_strobe = 1'b0;
        check("rs_restart_pos", int'(position), 57);
        step_check("rs_s2", 56, 1);
        step_check("rs_s3", 55, 1);
        step_check("rs_s4", 54, 0);

        // Coarse reset with a motion step: count still decrements
        load_and_start(4'd2);
        beam_x = 8'd50;
        reset_strobe = 1'b1;
        step_enable = 1'b1;
        tick();
        reset_strobe = 1'b0;
        step_enable = 1'b0;
        beam_x = 8'd200;
        check("rsstep_pos", int'(position), 54);
        check("rsstep_busy", int'(busy), 1);
        step_check("rsstep_s2", 53, 0);

        // Clear wins over write
        hmove_value = 4'd5;
        hmove_write = 1'b1;
        hmove_clear = 1'b1;
        tick();
        hmove_write = 1'b0;
        hmove_clear = 1'b0;
        hmove_strobe = 1'b1;
        tick();
        hmove_strobe = 1'b0;
        check("clear_wins_busy", int'(busy), 0);
        check("clear_wins_pos", int'(position), 53);

        // Asynchronous reset mid-motion
        load_and_start(4'd3);
        step_check("amid_s1", 52, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("amid_pos", int'(position), 0);
        check("amid_busy", int'(busy), 0);
        check("amid_strobe", int'(strobe), 0);
        #3;
        reset_n = 1'b1;
        tick();
        hmove_strobe = 1'b1;
        tick();
        hmove_strobe = 1'b0;
        check("post_rst_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
